// File: rtl/tartaruga_pkg.sv
// rtl/tartaruga_pkg.sv - shared reorder-buffer types and defaults
// Purpose: entry, allocation and writeback payload types used by rob_multi
// and its source-lookup helper, plus small shared helpers.
package tartaruga_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

   typedef logic [ROB_IDX_W-1:0] rob_idx_t;
   typedef logic [4:0]           reg_addr_t;
   typedef logic [31:0]          bus32_t;

   typedef struct packed {
      bus32_t    pc;
      bus32_t    instr;
      reg_addr_t rd;
      logic      write_enable;
      logic      store_to_mem;
      logic [15:0] kanata_id;
   } rob_alloc_t;

   typedef struct packed {
      bus32_t    result;
      bus32_t    new_pc;
      logic      branch_taken;
      logic [3:0] store_buffer_idx;
   } rob_wb_t;

   typedef struct packed {
      rob_alloc_t info;
      rob_wb_t    wb;
   } rob_entry_t;

   // True when the set bits form a run starting at bit 0 (e.g. 0, 1, 3, 7).
   function automatic logic is_contiguous(input logic [31:0] v);
      return ((v + 32'd1) & v) == 32'd0;
   endfunction

endpackage

// File: rtl/rob_src_lookup.sv
// rtl/rob_src_lookup.sv - youngest in-flight producer search for one source
// Ports:
//   valid_i, we_i, rd_i : per-entry valid, write_enable and destination
//   head_i, count_i     : occupied window of the buffer
//   addr_i              : source register to look up
//   hit_o, idx_o        : producer found, and its entry index
module rob_src_lookup
   import tartaruga_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   localparam int IW = $clog2(DEPTH),
   localparam int CW = IW + 1
) (
   input  logic [DEPTH-1:0]      valid_i,
   input  logic [DEPTH-1:0]      we_i,
   input  reg_addr_t [DEPTH-1:0] rd_i,
   input  logic [IW-1:0]         head_i,
   input  logic [CW-1:0]         count_i,
   input  reg_addr_t             addr_i,
   output logic                  hit_o,
   output logic [IW-1:0]         idx_o
);

   logic [IW-1:0] e;

   // Walk oldest to youngest; a later match overrides, so the youngest wins.
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      e     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         e = head_i + IW'(k);
         if ((CW'(k) < count_i) && valid_i[e] && we_i[e] &&
             (rd_i[e] == addr_i) && (addr_i != '0)) begin
            hit_o = 1'b1;
            idx_o = e;
         end
      end
   end

endmodule

// File: rtl/rob_multi.sv
// rtl/rob_multi.sv - multi-lane reorder buffer with lookup, flush and squash
// Ports:
//   clk_i, rstn_i, flush_i                 : clock, sync active-low reset, full flush
//   alloc_valid_i/entry_i, alloc_ready_o,
//   alloc_idx_o                            : in-order allocation, lanes from 0
//   wb_valid_i/idx_i/data_i                : writeback ports
//   squash_valid_i/idx_i                   : drop everything younger than idx
//   commit_valid_o/entry_o                 : in-order retirement lanes
//   rob_empty_o, rob_full_o                : occupancy status
//   src_addr_i, src_hit_o/idx_o/
//   src_completed_o/result_o               : youngest-producer lookup
module rob_multi
   import tartaruga_pkg::*;
#(
   parameter int DEPTH      = ROB_DEPTH,
   parameter int DISPATCH_W = 2,
   parameter int COMMIT_W   = 2,
   parameter int WB_PORTS   = 2,
   parameter int NUM_SRC    = 4,
   localparam int IW = $clog2(DEPTH),
   localparam int CW = IW + 1
) (
   input  logic                             clk_i,
   input  logic                             rstn_i,
   input  logic                             flush_i,
   input  logic [DISPATCH_W-1:0]            alloc_valid_i,
   input  rob_alloc_t [DISPATCH_W-1:0]      alloc_entry_i,
   output logic                             alloc_ready_o,
   output logic [DISPATCH_W-1:0][IW-1:0]    alloc_idx_o,
   input  logic [WB_PORTS-1:0]              wb_valid_i,
   input  logic [WB_PORTS-1:0][IW-1:0]      wb_idx_i,
   input  rob_wb_t [WB_PORTS-1:0]           wb_data_i,
   input  logic                             squash_valid_i,
   input  logic [IW-1:0]                    squash_idx_i,
   output logic [COMMIT_W-1:0]              commit_valid_o,
   output rob_entry_t [COMMIT_W-1:0]        commit_entry_o,
   output logic                             rob_empty_o,
   output logic                             rob_full_o,
   input  reg_addr_t [NUM_SRC-1:0]          src_addr_i,
   output logic [NUM_SRC-1:0]               src_hit_o,
   output logic [NUM_SRC-1:0][IW-1:0]       src_idx_o,
   output logic [NUM_SRC-1:0]               src_completed_o,
   output bus32_t [NUM_SRC-1:0]             src_result_o
);

   logic [IW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d, completed_q, completed_d;
   rob_entry_t       ent_q [DEPTH];
   rob_entry_t       ent_d [DEPTH];

   logic [IW-1:0]    sq_off;
   logic [IW-1:0]    ci;
   logic [CW-1:0]    n_commit, n_alloc;
   logic             go, store_seen, br_flush;

   // Credit comes from the registered count only; commits this cycle do not help.
   assign alloc_ready_o = (CW'(DEPTH) - count_q) >= CW'(DISPATCH_W);
   assign rob_empty_o   = (count_q == '0);
   assign rob_full_o    = (count_q == CW'(DEPTH));

   // Age of the squash point relative to head; anything older-or-equal survives.
   assign sq_off = squash_idx_i - head_q;

   always_comb begin
      for (int k = 0; k < DISPATCH_W; k++) begin
         alloc_idx_o[k] = tail_q + IW'(k);
      end
   end

   always_comb begin
      n_alloc = '0;
      for (int k = 0; k < DISPATCH_W; k++) begin
         if (alloc_valid_i[k] && alloc_ready_o) n_alloc = n_alloc + CW'(1);
      end
   end

   // Commit lanes stop at the first entry that is not ready, at a second store,
   // after a taken branch, or past the squash point (those entries are dying).
   always_comb begin
      go             = 1'b1;
      store_seen     = 1'b0;
      br_flush       = 1'b0;
      n_commit       = '0;
      ci             = '0;
      commit_valid_o = '0;
      for (int j = 0; j < COMMIT_W; j++) begin
         ci = head_q + IW'(j);
         commit_entry_o[j] = '0;
         if (go && valid_q[ci] && completed_q[ci] &&
             !(squash_valid_i && (IW'(j) > sq_off)) &&
             !(ent_q[ci].info.store_to_mem && store_seen)) begin
            commit_valid_o[j] = 1'b1;
            commit_entry_o[j] = ent_q[ci];
            n_commit          = n_commit + CW'(1);
            store_seen        = store_seen | ent_q[ci].info.store_to_mem;
            if (ent_q[ci].wb.branch_taken) begin
               br_flush = 1'b1;
               go       = 1'b0;
            end
         end else begin
            go = 1'b0;
         end
      end
   end

   always_comb begin
      valid_d     = valid_q;
      completed_d = completed_q;
      ent_d       = ent_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;

      // Highest port first so that port 0 has the final say on a collision.
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
         if (wb_valid_i[p] && valid_q[wb_idx_i[p]]) begin
            completed_d[wb_idx_i[p]] = 1'b1;
            ent_d[wb_idx_i[p]].wb    = wb_data_i[p];
         end
      end

      for (int j = 0; j < COMMIT_W; j++) begin
         if (commit_valid_o[j]) begin
            valid_d[head_q + IW'(j)]     = 1'b0;
            completed_d[head_q + IW'(j)] = 1'b0;
         end
      end
      head_d = head_q + n_commit[IW-1:0];

      if (flush_i || br_flush) begin
         valid_d     = '0;
         completed_d = '0;
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
      end else if (squash_valid_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if ((IW'(i) - head_q) > sq_off) begin
               valid_d[i]     = 1'b0;
               completed_d[i] = 1'b0;
            end
         end
         tail_d  = squash_idx_i + IW'(1);
         count_d = CW'(sq_off) + CW'(1) - n_commit;
      end else begin
         for (int k = 0; k < DISPATCH_W; k++) begin
            if (alloc_valid_i[k] && alloc_ready_o) begin
               valid_d[tail_q + IW'(k)]       = 1'b1;
               completed_d[tail_q + IW'(k)]   = 1'b0;
               ent_d[tail_q + IW'(k)].info    = alloc_entry_i[k];
               ent_d[tail_q + IW'(k)].wb      = '0;
            end
         end
         tail_d  = tail_q + n_alloc[IW-1:0];
         count_d = count_q - n_commit + n_alloc;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         valid_q     <= '0;
         completed_q <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         completed_q <= completed_d;
      end
   end

   // Payload is only observed through valid/completed, so it needs no reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_q[i] <= ent_d[i];
      end
   end

   logic [DEPTH-1:0]      we_vec;
   reg_addr_t [DEPTH-1:0] rd_vec;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         we_vec[i] = ent_q[i].info.write_enable;
         rd_vec[i] = ent_q[i].info.rd;
      end
   end

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      rob_src_lookup #(.DEPTH(DEPTH)) u_lookup (
         .valid_i (valid_q),
         .we_i    (we_vec),
         .rd_i    (rd_vec),
         .head_i  (head_q),
         .count_i (count_q),
         .addr_i  (src_addr_i[s]),
         .hit_o   (src_hit_o[s]),
         .idx_o   (src_idx_o[s])
      );
      assign src_completed_o[s] = src_hit_o[s] & completed_q[src_idx_o[s]];
      assign src_result_o[s]    = src_hit_o[s] ? ent_q[src_idx_o[s]].wb.result : '0;
   end

   logic wb_dup;

   always_comb begin
      wb_dup = 1'b0;
      for (int p = 0; p < WB_PORTS; p++) begin
         for (int q = p + 1; q < WB_PORTS; q++) begin
            if (wb_valid_i[p] && wb_valid_i[q] && (wb_idx_i[p] == wb_idx_i[q])) wb_dup = 1'b1;
         end
      end
   end

   ap_alloc_contig: assert property (@(posedge clk_i) disable iff (!rstn_i)
      is_contiguous(32'(alloc_valid_i)));
   ap_wb_unique: assert property (@(posedge clk_i) disable iff (!rstn_i)
      !wb_dup);
   ap_squash_valid: assert property (@(posedge clk_i) disable iff (!rstn_i)
      squash_valid_i |-> valid_q[squash_idx_i]);

endmodule

// File: tb/tb_rob_multi.sv
// tb/tb_rob_multi.sv - scoreboard bench for rob_multi with a queue-based model
module tb_rob_multi;
   import tartaruga_pkg::*;

   localparam int DEPTH = 16;
   localparam int DW    = 2;
   localparam int CWL   = 2;
   localparam int WP    = 2;
   localparam int NS    = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic flush;
   logic [DW-1:0]           alloc_valid;
   rob_alloc_t [DW-1:0]     alloc_entry;
   logic                    alloc_ready;
   logic [DW-1:0][3:0]      alloc_idx;
   logic [WP-1:0]           wb_valid;
   logic [WP-1:0][3:0]      wb_idx;
   rob_wb_t [WP-1:0]        wb_data;
   logic                    squash_valid;
   logic [3:0]              squash_idx;
   logic [CWL-1:0]          commit_valid;
   rob_entry_t [CWL-1:0]    commit_entry;
   logic                    rob_empty, rob_full;
   reg_addr_t [NS-1:0]      src_addr;
   logic [NS-1:0]           src_hit;
   logic [NS-1:0][3:0]      src_idx;
   logic [NS-1:0]           src_completed;
   bus32_t [NS-1:0]         src_result;

   always #5 clk = ~clk;

   rob_multi #(.DEPTH(DEPTH), .DISPATCH_W(DW), .COMMIT_W(CWL), .WB_PORTS(WP), .NUM_SRC(NS)) dut (
      .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
      .alloc_valid_i(alloc_valid), .alloc_entry_i(alloc_entry),
      .alloc_ready_o(alloc_ready), .alloc_idx_o(alloc_idx),
      .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data),
      .squash_valid_i(squash_valid), .squash_idx_i(squash_idx),
      .commit_valid_o(commit_valid), .commit_entry_o(commit_entry),
      .rob_empty_o(rob_empty), .rob_full_o(rob_full),
      .src_addr_i(src_addr), .src_hit_o(src_hit), .src_idx_o(src_idx),
      .src_completed_o(src_completed), .src_result_o(src_result)
   );

   // Model: in-flight instructions in program order.
   typedef struct { int idx; rob_alloc_t info; rob_wb_t wb; bit done; } m_ent_t;
   typedef struct { int cyc; int lane; rob_entry_t e; } exp_t;

   m_ent_t mq[$];
   exp_t   expq[$];
   int     m_head = 0;
   int     vectors = 0;
   int     miscompares = 0;
   int     cyc = 0;
   bit     started = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic clear_inputs();
      flush = 1'b0;
      alloc_valid = '0;
      alloc_entry = '0;
      wb_valid = '0;
      wb_idx = '0;
      wb_data = '0;
      squash_valid = 1'b0;
      squash_idx = '0;
      for (int s = 0; s < NS; s++) src_addr[s] = 5'($urandom_range(0, 7));
   endtask

   task automatic put_alloc(input int lane, input int pc, input int rd, input bit we, input bit st);
      alloc_valid[lane] = 1'b1;
      alloc_entry[lane].pc = 32'(pc);
      alloc_entry[lane].instr = $urandom;
      alloc_entry[lane].rd = 5'(rd);
      alloc_entry[lane].write_enable = we;
      alloc_entry[lane].store_to_mem = st;
      alloc_entry[lane].kanata_id = 16'($urandom);
   endtask

   task automatic put_wb(input int port, input int idx, input bit br);
      wb_valid[port] = 1'b1;
      wb_idx[port] = 4'(idx);
      wb_data[port].result = $urandom;
      wb_data[port].new_pc = $urandom;
      wb_data[port].branch_taken = br;
      wb_data[port].store_buffer_idx = 4'($urandom);
   endtask

   // One clock cycle: check pre-edge outputs against the model, queue the
   // expected retirements, then advance the model past the edge.
   task automatic tick();
      int ncom, sqpos, f;
      bit brf, st_seen, can_alloc;
      exp_t x;
      m_ent_t n;
      #1;
      cyc++;
      chk("alloc_ready", alloc_ready, mq.size() <= DEPTH - DW);
      chk("rob_empty", rob_empty, mq.size() == 0);
      chk("rob_full", rob_full, mq.size() == DEPTH);
      for (int k = 0; k < DW; k++) chk("alloc_idx", alloc_idx[k], (m_head + mq.size() + k) % DEPTH);
      for (int s = 0; s < NS; s++) begin
         f = -1;
         if (src_addr[s] != 0)
            for (int i = mq.size() - 1; i >= 0; i--)
               if (mq[i].info.write_enable && mq[i].info.rd == src_addr[s]) begin f = i; break; end
         chk("src_hit", src_hit[s], f >= 0);
         if (f >= 0) begin
            chk("src_idx", src_idx[s], mq[f].idx);
            chk("src_completed", src_completed[s], mq[f].done);
            if (mq[f].done) chk("src_result", src_result[s], mq[f].wb.result);
         end
      end
      sqpos = DEPTH;
      if (squash_valid) foreach (mq[i]) if (mq[i].idx == int'(squash_idx)) sqpos = i;
      ncom = 0; brf = 0; st_seen = 0;
      for (int j = 0; j < CWL && j < mq.size(); j++) begin
         if (!mq[j].done || j > sqpos || (mq[j].info.store_to_mem && st_seen)) break;
         x.cyc = cyc; x.lane = j; x.e.info = mq[j].info; x.e.wb = mq[j].wb;
         expq.push_back(x);
         ncom++;
         st_seen |= mq[j].info.store_to_mem;
         if (mq[j].wb.branch_taken) begin brf = 1; break; end
      end
      for (int p = WP - 1; p >= 0; p--)
         if (wb_valid[p]) foreach (mq[i]) if (mq[i].idx == int'(wb_idx[p])) begin
            mq[i].done = 1; mq[i].wb = wb_data[p];
         end
      can_alloc = mq.size() <= DEPTH - DW;
      if (flush || brf) begin
         mq.delete();
         m_head = 0;
      end else begin
         if (squash_valid) while (mq.size() > sqpos + 1) void'(mq.pop_back());
         repeat (ncom) begin void'(mq.pop_front()); m_head = (m_head + 1) % DEPTH; end
         if (!squash_valid && can_alloc)
            for (int k = 0; k < DW; k++) if (alloc_valid[k]) begin
               n.idx = (m_head + mq.size()) % DEPTH; n.info = alloc_entry[k]; n.wb = '0; n.done = 0;
               mq.push_back(n);
            end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   // Monitor: compares retirement lanes against the scoreboard every cycle.
   initial begin
      exp_t x;
      logic [CWL-1:0] m;
      wait (started);
      forever begin
         @(negedge clk);
         #3;
         m = '0;
         while (expq.size() > 0 && expq[0].cyc == cyc) begin
            x = expq.pop_front();
            m[x.lane] = 1'b1;
            chk("commit_entry", commit_entry[x.lane], x.e);
         end
         chk("commit_valid", commit_valid, m);
         for (int l = 0; l < CWL; l++) if (!m[l]) chk("commit_zero", commit_entry[l], '0);
      end
   end

   initial begin
      int r, nl, wi;
      clear_inputs();
      repeat (2) @(negedge clk);
      started = 1;
      @(negedge clk);
      rstn = 1'b1;

      // Fill to full, then an attempted allocation that must be dropped.
      for (int c = 0; c < 8; c++) begin
         put_alloc(0, 2 * c, (2 * c) % 8, 1, 0); put_alloc(1, 2 * c + 1, (2 * c + 1) % 8, 1, 0);
         tick();
      end
      put_alloc(0, 99, 1, 1, 0); put_alloc(1, 98, 1, 1, 0); tick();
      put_wb(0, 1, 0); put_wb(1, 0, 0); tick();
      tick();
      flush = 1; tick();

      // Taken branch at entry 0 suppresses entry 1 and empties the buffer.
      put_alloc(0, 100, 1, 1, 0); put_alloc(1, 101, 2, 1, 0); tick();
      put_alloc(0, 102, 3, 1, 0); put_alloc(1, 103, 4, 1, 0);
      put_wb(0, 0, 1); put_wb(1, 1, 0); tick();
      tick();
      put_alloc(0, 104, 1, 1, 0); put_alloc(1, 105, 2, 1, 0); tick();
      flush = 1; tick();

      // Two completed stores retire on consecutive cycles.
      put_alloc(0, 200, 0, 0, 1); put_alloc(1, 201, 0, 0, 1); tick();
      put_wb(0, 0, 0); put_wb(1, 1, 0); tick();
      tick(); tick();
      flush = 1; tick();

      // Squash behind entry 4 with a same-cycle writeback to entry 7.
      for (int c = 0; c < 5; c++) begin
         put_alloc(0, 300 + 2 * c, 7, 0, 0); put_alloc(1, 301 + 2 * c, 7, 0, 0); tick();
      end
      squash_valid = 1; squash_idx = 4'd4; put_wb(0, 7, 0);
      put_alloc(0, 400, 1, 1, 0); tick();
      put_alloc(0, 401, 1, 1, 0); put_alloc(1, 402, 1, 1, 0); tick();
      flush = 1; tick();

      // Two producers of x5 (entries 2 and 6); the younger one is incomplete.
      for (int c = 0; c < 4; c++) begin
         put_alloc(0, 500 + 2 * c, (2 * c == 2 || 2 * c == 6) ? 5 : 1, 1, 0);
         put_alloc(1, 501 + 2 * c, 3, 1, 0);
         tick();
      end
      put_wb(0, 2, 0); tick();
      src_addr[0] = 5'd5; src_addr[1] = 5'd0; src_addr[2] = 5'd5; src_addr[3] = 5'd3; tick();
      flush = 1; tick();

      // Same lookup across the wrap: move head to 14, then occupy 14..2.
      for (int c = 0; c < 7; c++) begin put_alloc(0, 600 + 2 * c, 1, 0, 0); put_alloc(1, 601 + 2 * c, 1, 0, 0); tick(); end
      for (int c = 0; c < 7; c++) begin put_wb(0, 2 * c, 0); put_wb(1, 2 * c + 1, 0); tick(); end
      tick();
      put_alloc(0, 700, 2, 1, 0); put_alloc(1, 701, 5, 1, 0); tick();
      put_alloc(0, 702, 2, 1, 0); put_alloc(1, 703, 5, 1, 0); tick();
      put_alloc(0, 704, 2, 1, 0); put_wb(0, 15, 0); tick();
      src_addr[0] = 5'd5; src_addr[1] = 5'd0; src_addr[2] = 5'd5; src_addr[3] = 5'd2; tick();
      flush = 1; tick();

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         r = $urandom_range(0, 99);
         if (r < 2) flush = 1;
         else if (r < 7 && mq.size() > 0) begin
            squash_valid = 1;
            squash_idx = 4'(mq[$urandom_range(0, mq.size() - 1)].idx);
         end
         nl = $urandom_range(0, 2);
         for (int k = 0; k < nl; k++)
            put_alloc(k, $urandom, $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
         for (int p = 0; p < WP; p++) begin
            if ($urandom_range(0, 1) == 1 && mq.size() > 0) begin
               if ($urandom_range(0, 9) == 0) wi = $urandom_range(0, DEPTH - 1);
               else wi = mq[$urandom_range(0, mq.size() - 1)].idx;
               if (!(p == 1 && wb_valid[0] && int'(wb_idx[0]) == wi))
                  put_wb(p, wi, $urandom_range(0, 19) == 0);
            end
         end
         tick();
      end
      tick();
      #5;
      chk("scoreboard_drained", expq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
